uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter between two packet sources: the command-response path (req0) and the nonce/status reporter (req1). It accepts whole packets over a valid/ready handshake and arbitrates round-robin between the two sources. Each packet is serialized into the link framing: length byte, two zero bytes, type byte, then payload bytes MSB-first. The block pulses the UART `transmit` strobe one byte at a time, paced by `is_transmitting`, so the RX state machine never blocks on TX.

---
 rtl/uart_tx_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that serializes packets from two sources onto one UART transmitter.
// Each packet is framed as: length byte (4+len), 0x00, 0x00, type, payload MSB-first.
module uart_tx_arbiter #(
    parameter int unsigned PAYLOAD_BYTES = 8
) (
    input  logic                         sys_clk,
    input  logic                         rst_n,

    input  logic                         req0_valid,
    output logic                         req0_ready,
    input  logic [7:0]                   req0_type,
    input  logic [3:0]                   req0_len,
    input  logic [PAYLOAD_BYTES*8-1:0]   req0_payload,

    input  logic                         req1_valid,
    output logic                         req1_ready,
    input  logic [7:0]                   req1_type,
    input  logic [3:0]                   req1_len,
    input  logic [PAYLOAD_BYTES*8-1:0]   req1_payload,

    output logic                         uart_transmit,
    output logic [7:0]                   uart_tx_byte,
    input  logic                         uart_is_transmitting,

    output logic                         busy,
    output logic                         grant,
    output logic                         err_len
);

    localparam int unsigned PW = PAYLOAD_BYTES * 8;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StSend     = 2'd1;
    localparam logic [1:0] StWaitBusy = 2'd2;
    localparam logic [1:0] StWaitDone = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic          grant_q, grant_d;
    logic          busy_q, busy_d;
    logic          ready0_q, ready0_d;
    logic          ready1_q, ready1_d;
    logic          err_len_q, err_len_d;
    logic          transmit_q, transmit_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic [3:0]    idx_q, idx_d;
    logic [3:0]    total_q, total_d;
    logic [7:0]    type_q, type_d;
    logic [PW-1:0] shift_q, shift_d;

    logic          sel;
    logic [3:0]    sel_len;
    logic [7:0]    sel_type;
    logic [PW-1:0] sel_payload;
    logic          oversize;
    logic          accept_hold;
    logic [7:0]    cur_byte;

    // Pick the winning source: a tie goes to whichever source was not accepted last.
    always_comb begin
        sel = 1'b0;
        if (req0_valid && req1_valid) begin
            sel = ~last_grant_q;
        end else if (req1_valid) begin
            sel = 1'b1;
        end
        sel_len     = sel ? req1_len     : req0_len;
        sel_type    = sel ? req1_type    : req0_type;
        sel_payload = sel ? req1_payload : req0_payload;
        oversize    = 32'(sel_len) > PAYLOAD_BYTES;
        // While a ready pulse is out the source has not yet dropped valid; don't re-accept it.
        accept_hold = ready0_q | ready1_q;
    end

    // Frame byte for the current index; payload bytes come off the top of the shift register.
    always_comb begin
        case (idx_q)
            4'd0:       cur_byte = {4'h0, total_q};
            4'd1, 4'd2: cur_byte = 8'h00;
            4'd3:       cur_byte = type_q;
            default:    cur_byte = shift_q[PW-1 -: 8];
        endcase
    end

    // Next-state logic for the packet FSM and all registered outputs.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        ready0_d     = 1'b0;
        ready1_d     = 1'b0;
        err_len_d    = 1'b0;
        transmit_d   = 1'b0;
        tx_byte_d    = tx_byte_q;
        idx_d        = idx_q;
        total_d      = total_q;
        type_d       = type_q;
        shift_d      = shift_q;

        case (state_q)
            StIdle: begin
                if (!accept_hold && (req0_valid || req1_valid)) begin
                    last_grant_d = sel;
                    ready0_d     = ~sel;
                    ready1_d     = sel;
                    if (oversize) begin
                        err_len_d = 1'b1;
                    end else begin
                        grant_d = sel;
                        busy_d  = 1'b1;
                        idx_d   = 4'd0;
                        total_d = 4'd4 + sel_len;
                        type_d  = sel_type;
                        shift_d = sel_payload;
                        state_d = StSend;
                    end
                end
            end
            StSend: begin
                // Holding here while the UART is busy covers a byte left over from before reset.
                if (!uart_is_transmitting) begin
                    transmit_d = 1'b1;
                    tx_byte_d  = cur_byte;
                    if (idx_q >= 4'd4) begin
                        shift_d = shift_q << 8;
                    end
                    state_d = StWaitBusy;
                end
            end
            StWaitBusy: begin
                if (uart_is_transmitting) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!uart_is_transmitting) begin
                    if (idx_q == total_q - 4'd1) begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            busy_q       <= 1'b0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            err_len_q    <= 1'b0;
            transmit_q   <= 1'b0;
            tx_byte_q    <= 8'h00;
            idx_q        <= 4'd0;
            total_q      <= 4'd0;
            type_q       <= 8'h00;
            shift_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
            err_len_q    <= err_len_d;
            transmit_q   <= transmit_d;
            tx_byte_q    <= tx_byte_d;
            idx_q        <= idx_d;
            total_q      <= total_d;
            type_q       <= type_d;
            shift_q      <= shift_d;
        end
    end

    assign req0_ready    = ready0_q;
    assign req1_ready    = ready1_q;
    assign uart_transmit = transmit_q;
    assign uart_tx_byte  = tx_byte_q;
    assign busy          = busy_q;
    assign grant         = grant_q;
    assign err_len       = err_len_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART busy model.
module tb_uart_tx_arbiter;

    logic        sys_clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [7:0]  req0_type;
    logic [3:0]  req0_len;
    logic [63:0] req0_payload;
    logic        req1_valid, req1_ready;
    logic [7:0]  req1_type;
    logic [3:0]  req1_len;
    logic [63:0] req1_payload;
    logic        uart_transmit;
    logic [7:0]  uart_tx_byte;
    logic        uart_is_transmitting;
    logic        busy, grant, err_len;

    int checks = 0;
    int errors = 0;

    // UART model state (not reset by rst_n: it is a separate block)
    int          hold_cycles = 3;
    int          busy_cnt    = 0;
    logic        seen_busy   = 1'b1;
    int          viol        = 0;
    int          r0_cnt      = 0;
    int          r1_cnt      = 0;
    int          err_cnt     = 0;
    logic [7:0]  byte_log[$];
    logic [7:0]  exp_q[$];

    uart_tx_arbiter #(.PAYLOAD_BYTES(8)) dut (
        .sys_clk              (sys_clk),
        .rst_n                (rst_n),
        .req0_valid           (req0_valid),
        .req0_ready           (req0_ready),
        .req0_type            (req0_type),
        .req0_len             (req0_len),
        .req0_payload         (req0_payload),
        .req1_valid           (req1_valid),
        .req1_ready           (req1_ready),
        .req1_type            (req1_type),
        .req1_len             (req1_len),
        .req1_payload         (req1_payload),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting),
        .busy                 (busy),
        .grant                (grant),
        .err_len              (err_len)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    assign uart_is_transmitting = (busy_cnt != 0);

    // UART model: busy for hold_cycles after each sampled strobe; flags strobes during busy
    always @(posedge sys_clk) begin
        if (uart_is_transmitting) seen_busy <= 1'b1;
        if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        if (uart_transmit) begin
            if (uart_is_transmitting || !seen_busy) viol <= viol + 1;
            byte_log.push_back(uart_tx_byte);
            busy_cnt  <= hold_cycles;
            seen_busy <= 1'b0;
        end
        if (req0_ready) r0_cnt <= r0_cnt + 1;
        if (req1_ready) r1_cnt <= r1_cnt + 1;
        if (err_len)    err_cnt <= err_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        byte_log.delete();
        r0_cnt  = 0;
        r1_cnt  = 0;
        err_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge sys_clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int src, input logic [7:0] t, input logic [3:0] l,
                           input logic [63:0] p);
        if (src == 0) begin
            req0_type = t; req0_len = l; req0_payload = p; req0_valid = 1'b1;
        end else begin
            req1_type = t; req1_len = l; req1_payload = p; req1_valid = 1'b1;
        end
    endtask

    // Waits (bounded) for the ready pulse of src at a negedge, then drops that valid.
    task automatic wait_ready(input int src);
        int n;
        for (n = 0; n < 3000; n++) begin
            @(negedge sys_clk);
            if (src == 0 && req0_ready === 1'b1) break;
            if (src == 1 && req1_ready === 1'b1) break;
        end
        if (n == 3000) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: src %0d got no ready, required one", src);
        end
        if (src == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_not_busy(input int bound);
        int n;
        for (n = 0; n < bound; n++) begin
            @(negedge sys_clk);
            if (busy === 1'b0) break;
        end
        if (n == bound) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy still %b, required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_type = 8'h00; req0_len = 4'd0; req0_payload = 64'h0;
        req1_type = 8'h00; req1_len = 4'd0; req1_payload = 64'h0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b, required 00", {req0_ready, req1_ready});
        end
        checks++;
        if (uart_transmit !== 1'b0) begin
            errors++; $display("FAIL reset_transmit: got %b, required 0", uart_transmit);
        end
        checks++;
        if (uart_tx_byte !== 8'h00) begin
            errors++; $display("FAIL reset_tx_byte: got %h, required 00", uart_tx_byte);
        end
        checks++;
        if ({busy, grant, err_len} !== 3'b000) begin
            errors++; $display("FAIL reset_status: got %b, required 000", {busy, grant, err_len});
        end
        rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_single_packet();
        clear_logs();
        hold_cycles = 3;
        set_req(0, 8'h00, 4'd8, 64'hDEADBEEF13370D13);
        wait_ready(0);
        wait_not_busy(2000);
        exp_q = '{8'h0C, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                  8'h13, 8'h37, 8'h0D, 8'h13};
        checks++;
        if (byte_log.size() !== 12) begin
            errors++; $display("FAIL single_count: got %0d strobes, required 12", byte_log.size());
        end
        for (int i = 0; i < 12 && i < byte_log.size(); i++) begin
            checks++;
            if (byte_log[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL single_byte%0d: got %h, required %h", i, byte_log[i], exp_q[i]);
            end
        end
        checks++;
        if (r0_cnt !== 1 || r1_cnt !== 0) begin
            errors++; $display("FAIL single_ready: got r0=%0d r1=%0d, required 1 0", r0_cnt, r1_cnt);
        end
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL single_spacing: got %0d violations, required 0", viol);
        end
    endtask

    task automatic test_zero_payload();
        clear_logs();
        set_req(1, 8'h01, 4'd0, 64'h0);
        wait_ready(1);
        checks++;
        if (grant !== 1'b1) begin
            errors++; $display("FAIL zero_grant: got %b, required 1", grant);
        end
        wait_not_busy(500);
        exp_q = '{8'h04, 8'h00, 8'h00, 8'h01};
        checks++;
        if (byte_log.size() !== 4) begin
            errors++; $display("FAIL zero_count: got %0d strobes, required 4", byte_log.size());
        end
        for (int i = 0; i < 4 && i < byte_log.size(); i++) begin
            checks++;
            if (byte_log[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL zero_byte%0d: got %h, required %h", i, byte_log[i], exp_q[i]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL zero_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_alternation();
        int n0 = 2;
        int n1 = 2;
        int order[$];
        int c;
        do_reset();
        clear_logs();
        @(negedge sys_clk);
        set_req(0, 8'hA0, 4'd0, 64'h0);
        set_req(1, 8'hB0, 4'd2, 64'h5A6B_0000_0000_0000);
        for (c = 0; c < 3000; c++) begin
            @(negedge sys_clk);
            if (req0_ready === 1'b1) begin
                order.push_back(0);
                n0--;
                if (n0 == 0) req0_valid = 1'b0; else req0_type = 8'hA1;
            end
            if (req1_ready === 1'b1) begin
                order.push_back(1);
                n1--;
                if (n1 == 0) req1_valid = 1'b0; else req1_type = 8'hB1;
            end
            if (n0 == 0 && n1 == 0 && busy === 1'b0) break;
        end
        if (c == 3000) begin
            checks++; errors++;
            $display("FAIL alt_timeout: %0d packets accepted, required 4", order.size());
        end
        checks++;
        if (order.size() !== 4) begin
            errors++; $display("FAIL alt_count: got %0d accepts, required 4", order.size());
        end else begin
            checks++;
            if ({order[0][0], order[1][0], order[2][0], order[3][0]} !== 4'b0101) begin
                errors++;
                $display("FAIL alt_order: got %0d%0d%0d%0d, required 0101",
                         order[0], order[1], order[2], order[3]);
            end
        end
        exp_q = '{8'h04, 8'h00, 8'h00, 8'hA0,
                  8'h06, 8'h00, 8'h00, 8'hB0, 8'h5A, 8'h6B,
                  8'h04, 8'h00, 8'h00, 8'hA1,
                  8'h06, 8'h00, 8'h00, 8'hB1, 8'h5A, 8'h6B};
        checks++;
        if (byte_log.size() !== 20) begin
            errors++; $display("FAIL alt_bytes: got %0d strobes, required 20", byte_log.size());
        end
        for (int i = 0; i < 20 && i < byte_log.size(); i++) begin
            checks++;
            if (byte_log[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL alt_byte%0d: got %h, required %h", i, byte_log[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_oversize();
        int c;
        do_reset();
        clear_logs();
        set_req(0, 8'h55, 4'd9, 64'h1122334455667788);
        for (c = 0; c < 50; c++) begin
            @(negedge sys_clk);
            if (req0_ready === 1'b1) break;
        end
        checks++;
        if (c == 50 || err_len !== 1'b1) begin
            errors++;
            $display("FAIL over_err_with_ready: got ready=%b err=%b, required 1 1",
                     req0_ready, err_len);
        end
        req0_valid = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({req0_ready, err_len} !== 2'b00) begin
            errors++;
            $display("FAIL over_pulse_width: got %b, required 00", {req0_ready, err_len});
        end
        repeat (10) @(negedge sys_clk);
        checks++;
        if (byte_log.size() !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL over_no_send: got %0d strobes busy=%b, required 0 0",
                     byte_log.size(), busy);
        end
        checks++;
        if (err_cnt !== 1) begin
            errors++; $display("FAIL over_err_count: got %0d, required 1", err_cnt);
        end
        // last_grant is now 0, so a tie goes to req1
        set_req(0, 8'hC0, 4'd0, 64'h0);
        set_req(1, 8'hC1, 4'd0, 64'h0);
        for (c = 0; c < 50; c++) begin
            @(negedge sys_clk);
            if (req0_ready === 1'b1 || req1_ready === 1'b1) break;
        end
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL over_tie_winner: got r0=%b r1=%b, required 0 1", req0_ready, req1_ready);
        end
        req1_valid = 1'b0;
        wait_ready(0);
        wait_not_busy(500);
        exp_q = '{8'h04, 8'h00, 8'h00, 8'hC1, 8'h04, 8'h00, 8'h00, 8'hC0};
        checks++;
        if (byte_log.size() !== 8) begin
            errors++; $display("FAIL over_tie_count: got %0d strobes, required 8", byte_log.size());
        end
        for (int i = 0; i < 8 && i < byte_log.size(); i++) begin
            checks++;
            if (byte_log[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL over_tie_byte%0d: got %h, required %h", i, byte_log[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        int c;
        clear_logs();
        hold_cycles = 20;
        set_req(0, 8'h00, 4'd8, 64'hDEADBEEF13370D13);
        wait_ready(0);
        for (c = 0; c < 1000; c++) begin
            @(negedge sys_clk);
            if (byte_log.size() >= 3) break;
        end
        @(negedge sys_clk);
        rst_n = 1'b0;
        @(negedge sys_clk);
        checks++;
        if ({req0_ready, req1_ready, uart_transmit, uart_tx_byte, busy, grant, err_len} !== 14'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got tx=%b byte=%h busy=%b grant=%b, required all 0",
                     uart_transmit, uart_tx_byte, busy, grant);
        end
        rst_n = 1'b1;
        set_req(1, 8'h22, 4'd0, 64'h0);
        wait_ready(1);
        wait_not_busy(1000);
        exp_q = '{8'h0C, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h22};
        checks++;
        if (byte_log.size() !== 7) begin
            errors++; $display("FAIL midrst_count: got %0d strobes, required 7", byte_log.size());
        end
        for (int i = 0; i < 7 && i < byte_log.size(); i++) begin
            checks++;
            if (byte_log[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midrst_byte%0d: got %h, required %h", i, byte_log[i], exp_q[i]);
            end
        end
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL midrst_spacing: got %0d violations, required 0", viol);
        end
    endtask

    task automatic test_slow_uart();
        clear_logs();
        hold_cycles = 1250;
        set_req(1, 8'h33, 4'd2, 64'h817E_0000_0000_0000);
        wait_ready(1);
        wait_not_busy(20000);
        exp_q = '{8'h06, 8'h00, 8'h00, 8'h33, 8'h81, 8'h7E};
        checks++;
        if (byte_log.size() !== 6) begin
            errors++; $display("FAIL slow_count: got %0d strobes, required 6", byte_log.size());
        end
        for (int i = 0; i < 6 && i < byte_log.size(); i++) begin
            checks++;
            if (byte_log[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL slow_byte%0d: got %h, required %h", i, byte_log[i], exp_q[i]);
            end
        end
        checks++;
        if (viol !== 0) begin
            errors++; $display("FAIL slow_spacing: got %0d violations, required 0", viol);
        end
        hold_cycles = 3;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_zero_payload();
        test_alternation();
        test_oversize();
        test_reset_mid_packet();
        test_slow_uart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
